// File: rtl/hs_sync_receiver.sv
// Clocked sink for a 4-phase bundled-data channel: synchronizes Rreq, captures data plus dual-rail error, acks, and queues words.
// Optional HS_TIMEOUT_EN adds a TIMEOUT parameter and a sticky timeout output that aborts stalled handshakes.
module hs_sync_receiver #(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
`ifdef HS_TIMEOUT_EN
   ,
   parameter int TIMEOUT     = 64
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Rreq,
   input  logic [DATA_W-1:0] Rdata,
   input  logic              Err1,
   input  logic              Err0,
   output logic              Rack,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   output logic [CNT_W-1:0]  hs_count,
   output logic              proto_err,
`ifdef HS_TIMEOUT_EN
   output logic              timeout,
`endif
   output logic [1:0]        dbg_state
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EVAL    = 2'd1,
      ACK_HI  = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t state, next_state;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_s;
   logic                   rack_q, rack_d;
   logic                   push, push_err, set_proto, inc_count;
   logic [DATA_W:0]        push_word;

   logic [DATA_W:0] mem [DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr, wr_next, rd_next;
   logic            full, pop;
   logic [DATA_W:0] head_next;

`ifdef HS_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_cnt;
   logic          tmo_fire, tmo_rel;
`endif

   // Rreq crosses in here; only sync_q[SYNC_STAGES-1] is used downstream.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= '0;
      else      sync_q <= {sync_q[SYNC_STAGES-2:0], Rreq};
   end
   assign req_s = sync_q[SYNC_STAGES-1];

   // State register plus the registered Rack and counters it owns.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rack_q    <= 1'b0;
         hs_count  <= '0;
         proto_err <= 1'b0;
      end else begin
         state  <= next_state;
         rack_q <= rack_d;
         if (inc_count) hs_count  <= hs_count + CNT_W'(1);
         if (set_proto) proto_err <= 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      push       = 1'b0;
      push_err   = 1'b0;
      set_proto  = 1'b0;
`ifdef HS_TIMEOUT_EN
      tmo_fire   = 1'b0;
`endif
      case (state)
         IDLE:    if (req_s && !full) next_state = EVAL;
         EVAL: begin
            case ({Err1, Err0})
               2'b01: begin push = 1'b1; next_state = ACK_HI; end
               2'b10: begin push = 1'b1; push_err = 1'b1; next_state = ACK_HI; end
               2'b11: begin
                  push = 1'b1; push_err = 1'b1; set_proto = 1'b1; next_state = ACK_HI;
               end
               default: next_state = EVAL;
            endcase
         end
         ACK_HI:  if (!req_s) next_state = RELEASE;
         default: next_state = IDLE;
      endcase
`ifdef HS_TIMEOUT_EN
      if ((state == EVAL || state == ACK_HI) && tmo_cnt == TW'(TIMEOUT - 1)) begin
         next_state = RELEASE;
         push       = 1'b0;
         push_err   = 1'b0;
         set_proto  = 1'b0;
         tmo_fire   = 1'b1;
      end
`endif
   end

   always_comb begin
      rack_d    = (next_state == ACK_HI);
`ifdef HS_TIMEOUT_EN
      inc_count = (state == RELEASE) && !tmo_rel;
`else
      inc_count = (state == RELEASE);
`endif
   end

   assign Rack      = rack_q;
   assign dbg_state = state;

`ifdef HS_TIMEOUT_EN
   // Counts consecutive cycles spent in EVAL/ACK_HI; tmo_rel marks an aborted RELEASE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt <= '0;
         timeout <= 1'b0;
         tmo_rel <= 1'b0;
      end else begin
         if (state == RELEASE) tmo_rel <= 1'b0;
         if (tmo_fire) begin
            tmo_cnt <= '0;
            timeout <= 1'b1;
            tmo_rel <= 1'b1;
         end else if (state == EVAL || state == ACK_HI) begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end else begin
            tmo_cnt <= '0;
         end
      end
   end
`endif

   // Output port: a word transfers on any cycle where out_valid && out_ready are both high;
   // out_valid never depends on out_ready, and the head holds steady until it is taken.
   assign push_word = {push_err, Rdata};
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign out_valid = (wr_ptr != rd_ptr);
   assign pop       = out_valid && out_ready;
   assign wr_next   = wr_ptr + (AW + 1)'(push);
   assign rd_next   = rd_ptr + (AW + 1)'(pop);

   // A word pushed into an empty (or just-emptied) FIFO bypasses memory into the head register.
   assign head_next = (push && wr_ptr[AW-1:0] == rd_next[AW-1:0]) ? push_word
                                                                  : mem[rd_next[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_word;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         out_data <= '0;
         out_err  <= 1'b0;
      end else begin
         wr_ptr <= wr_next;
         rd_ptr <= rd_next;
         if (wr_next != rd_next) {out_err, out_data} <= head_next;
      end
   end

endmodule
